// File: rtl/pkt_cache_wr_if.sv
// pkt_cache_wr_if: packet-in, buffer-address, RAM-write and status signals
// of the packet cache writer, grouped into one bundle.
//   slave  : the cache writer itself (consumes packet lines, drives RAM/status)
//   master : the surrounding logic (drives packet lines/addresses, observes results)
interface pkt_cache_wr_if;
    logic [133:0] in_pkt_data;
    logic         in_pkt_data_wr;
    logic [11:0]  in_waddr;
    logic         in_waddr_wr;
    logic [7:0]   in_buf_id;

    logic [133:0] out_ram_wdata;
    logic [11:0]  out_ram_waddr;
    logic         out_ram_wr;

    logic         out_addr_valid;
    logic         out_addr_valid_wr;
    logic [15:0]  out_desc;
    logic         out_desc_wr;
    logic [15:0]  out_drop_cnt;

    modport slave (
        input  in_pkt_data, in_pkt_data_wr, in_waddr, in_waddr_wr, in_buf_id,
        output out_ram_wdata, out_ram_waddr, out_ram_wr,
        output out_addr_valid, out_addr_valid_wr, out_desc, out_desc_wr, out_drop_cnt
    );

    modport master (
        output in_pkt_data, in_pkt_data_wr, in_waddr, in_waddr_wr, in_buf_id,
        input  out_ram_wdata, out_ram_waddr, out_ram_wr,
        input  out_addr_valid, out_addr_valid_wr, out_desc, out_desc_wr, out_drop_cnt
    );
endinterface

// File: rtl/pkt_cache_wr.sv
// pkt_cache_wr: writes incoming packet lines into a 128-line buffer of the
// data cache and reports per-packet results to the address manager.
// Line type in bits [133:132]: 01 head, 10 tail, 11/00 body.
// Every output is registered: RAM write one cycle after the line, result
// pulse one cycle after the tail, one line per cycle, no backpressure.
// Optional feature: define PKT_CACHE_OVF_CHK_EN to drop packets longer than
// 128 lines instead of wrapping inside the buffer.
module pkt_cache_wr (
    input  logic          clk,
    input  logic          rst_n,
    pkt_cache_wr_if.slave bus
);
    localparam int DATA_W = 134;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DROP   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
    logic [7:0]          offset_q, offset_d;
    logic [7:0]          buf_id_q, buf_id_d;
    logic                cap_id_q, cap_id_d;
    logic                have_buf_q, have_buf_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0]   ram_waddr_q, ram_waddr_d;
    logic                ram_wr_q, ram_wr_d;
    logic                addr_valid_q, addr_valid_d;
    logic                addr_valid_wr_q, addr_valid_wr_d;
    logic [15:0]         desc_q, desc_d;
    logic                desc_wr_q, desc_wr_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [1:0]          line_type;
    logic                is_head, is_tail, is_body;
    logic [ADDR_W-1:0]   head_addr;
    logic [ADDR_W-1:0]   line_addr;
    logic [7:0]          cur_buf_id;
    logic                ovf_hit;

    // Saturating increment for the drop counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign line_type = bus.in_pkt_data[133:132];
    assign is_head   = bus.in_pkt_data_wr && (line_type == 2'b01);
    assign is_tail   = bus.in_pkt_data_wr && (line_type == 2'b10);
    assign is_body   = bus.in_pkt_data_wr && ((line_type == 2'b11) || (line_type == 2'b00));

    // A head arriving together with an address pulse uses the fresh address.
    assign head_addr = bus.in_waddr_wr ? bus.in_waddr : base_addr_q;
    // Lines after the head stay inside the 128-line buffer.
    assign line_addr = {base_addr_q[11:7], offset_q[6:0]};
    // The ID is presented the cycle after the head; a 2-line packet's tail
    // lands on that same cycle, so the live input is used for its descriptor.
    assign cur_buf_id = cap_id_q ? bus.in_buf_id : buf_id_q;

`ifdef PKT_CACHE_OVF_CHK_EN
    assign ovf_hit = offset_q[7];
`else
    assign ovf_hit = 1'b0;
`endif

    // Next-state, datapath and output strobe computation.
    always_comb begin
        state_d         = state_q;
        base_addr_d     = base_addr_q;
        offset_d        = offset_q;
        buf_id_d        = cur_buf_id;
        cap_id_d        = 1'b0;
        have_buf_d      = have_buf_q;
        ovf_d           = ovf_q;
        ram_wdata_d     = ram_wdata_q;
        ram_waddr_d     = ram_waddr_q;
        ram_wr_d        = 1'b0;
        addr_valid_d    = 1'b0;
        addr_valid_wr_d = 1'b0;
        desc_d          = desc_q;
        desc_wr_d       = 1'b0;
        drop_cnt_d      = drop_cnt_q;

        case (state_q)
            // REPORT only exists to show the result pulse; inputs are
            // treated exactly as in IDLE so back-to-back packets work.
            ST_IDLE, ST_REPORT: begin
                if (state_q == ST_REPORT) begin
                    state_d = ST_IDLE;
                end
                if (bus.in_waddr_wr) begin
                    base_addr_d = bus.in_waddr;
                    state_d     = ST_ARMED;
                end
                if (is_head) begin
                    if (bus.in_waddr_wr) begin
                        ram_wr_d    = 1'b1;
                        ram_waddr_d = head_addr;
                        ram_wdata_d = bus.in_pkt_data;
                        offset_d    = 8'd1;
                        cap_id_d    = 1'b1;
                        ovf_d       = 1'b0;
                        state_d     = ST_WRITE;
                    end else begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        have_buf_d = 1'b0;
                        ovf_d      = 1'b0;
                        state_d    = ST_DROP;
                    end
                end
            end

            ST_ARMED: begin
                if (bus.in_waddr_wr) begin
                    base_addr_d = bus.in_waddr;
                end
                if (is_head) begin
                    ram_wr_d    = 1'b1;
                    ram_waddr_d = head_addr;
                    ram_wdata_d = bus.in_pkt_data;
                    offset_d    = 8'd1;
                    cap_id_d    = 1'b1;
                    ovf_d       = 1'b0;
                    state_d     = ST_WRITE;
                end
            end

            // The buffer is in use here, so address pulses are not taken.
            ST_WRITE: begin
                if (is_head) begin
                    // Missing tail: give the buffer back, drop the new packet.
                    addr_valid_wr_d = 1'b1;
                    drop_cnt_d      = sat_inc(drop_cnt_q);
                    have_buf_d      = 1'b0;
                    ovf_d           = 1'b0;
                    state_d         = ST_DROP;
                end else if (is_body || is_tail) begin
                    if (ovf_hit) begin
                        if (is_tail) begin
                            addr_valid_wr_d = 1'b1;
                            drop_cnt_d      = sat_inc(drop_cnt_q);
                            state_d         = ST_IDLE;
                        end else begin
                            have_buf_d = 1'b0;
                            ovf_d      = 1'b1;
                            state_d    = ST_DROP;
                        end
                    end else begin
                        ram_wr_d    = 1'b1;
                        ram_waddr_d = line_addr;
                        ram_wdata_d = bus.in_pkt_data;
                        offset_d    = offset_q + 8'd1;
                        if (is_tail) begin
                            addr_valid_d    = 1'b1;
                            addr_valid_wr_d = 1'b1;
                            desc_d          = {cur_buf_id, offset_q + 8'd1};
                            desc_wr_d       = 1'b1;
                            state_d         = ST_REPORT;
                        end
                    end
                end
            end

            // Discard until the tail; an address seen meanwhile arms on exit.
            ST_DROP: begin
                if (bus.in_waddr_wr) begin
                    base_addr_d = bus.in_waddr;
                    have_buf_d  = 1'b1;
                end
                if (is_tail) begin
                    if (ovf_q) begin
                        addr_valid_wr_d = 1'b1;
                        drop_cnt_d      = sat_inc(drop_cnt_q);
                    end
                    ovf_d      = 1'b0;
                    have_buf_d = 1'b0;
                    state_d    = (have_buf_q || bus.in_waddr_wr) ? ST_ARMED : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, context and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            base_addr_q     <= '0;
            offset_q        <= '0;
            buf_id_q        <= '0;
            cap_id_q        <= 1'b0;
            have_buf_q      <= 1'b0;
            ovf_q           <= 1'b0;
            ram_wdata_q     <= '0;
            ram_waddr_q     <= '0;
            ram_wr_q        <= 1'b0;
            addr_valid_q    <= 1'b0;
            addr_valid_wr_q <= 1'b0;
            desc_q          <= '0;
            desc_wr_q       <= 1'b0;
            drop_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            base_addr_q     <= base_addr_d;
            offset_q        <= offset_d;
            buf_id_q        <= buf_id_d;
            cap_id_q        <= cap_id_d;
            have_buf_q      <= have_buf_d;
            ovf_q           <= ovf_d;
            ram_wdata_q     <= ram_wdata_d;
            ram_waddr_q     <= ram_waddr_d;
            ram_wr_q        <= ram_wr_d;
            addr_valid_q    <= addr_valid_d;
            addr_valid_wr_q <= addr_valid_wr_d;
            desc_q          <= desc_d;
            desc_wr_q       <= desc_wr_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    assign bus.out_ram_wdata     = ram_wdata_q;
    assign bus.out_ram_waddr     = ram_waddr_q;
    assign bus.out_ram_wr        = ram_wr_q;
    assign bus.out_addr_valid    = addr_valid_q;
    assign bus.out_addr_valid_wr = addr_valid_wr_q;
    assign bus.out_desc          = desc_q;
    assign bus.out_desc_wr       = desc_wr_q;
    assign bus.out_drop_cnt      = drop_cnt_q;

endmodule
